input_script_player: RTL and testbench
======================================

Name: input_script_player

Overview:
- Synthesizable, parametrised stimulus sequencer that replays a stored script of timed KEY/SW events into the tile game.
- Runs at board level, between the physical DE1 KEY/SW pins and the game core. Used for attract/demo mode and for on-board self-test without a host bench.
- When idle, physical inputs pass straight through.
- When running, the outputs come from the script: per-entry delay, active-low key mask, switch word, optional loop.

Parameters:
- N_KEYS, 4, number of active-low key lines.
- N_SW, 10, number of switch lines.
- DEPTH, 16, script entries (power of two). AW = clog2(DEPTH).
- DELAY_W, 16, width of the per-entry delay field.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  start request, sampled only in IDLE or DONE.
- abort  in  1  return to IDLE, sampled in any state.
- loop  in  1  1 = wrap to entry 0 after the last entry. Sampled in APPLY.
- KEY_in  in  N_KEYS  physical keys (active-low).
- SW_in  in  N_SW  physical switches.
- wr_en  in  1  script write strobe.
- wr_addr  in  AW  script entry index.
- wr_delay  in  DELAY_W  hold cycles before this entry applies.
- wr_key  in  N_KEYS  key value for the entry (active-low).
- wr_sw  in  N_SW  switch value for the entry.
- wr_last  in  1  marks the final entry.
- KEY_out  out  N_KEYS  registered keys to the game core.
- SW_out  out  N_SW  registered switches to the game core.
- busy  out  1  high in LOAD, WAIT and APPLY.
- done  out  1  high in DONE.
- step_idx  out  AW  current entry index.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, idx=0, cnt=0, KEY_out=all ones, SW_out=0, busy=0, done=0.
- Reset does not clear script memory. Reset mid-run aborts immediately and takes priority over every other input.
- Script memory: register array with combinational read by idx.
  - Written on wr_en when busy=0.
  - wr_en while busy=1 is ignored.
- IDLE:
  - KEY_out<=KEY_in, SW_out<=SW_in (one-cycle registered passthrough).
  - On start: idx<=0, KEY_out<=all ones, SW_out<=0, go to LOAD.
- LOAD: cnt<=delay[idx]; go to WAIT.
- WAIT:
  - If cnt==0, go to APPLY; otherwise cnt<=cnt-1.
  - WAIT lasts delay+1 cycles.
- APPLY: KEY_out<=key[idx], SW_out<=sw[idx]. Next state:
  - If last[idx] or idx==DEPTH-1: with loop=1, idx<=0 and go to LOAD; with loop=0, go to DONE.
  - Otherwise idx<=idx+1 and go to LOAD.
- DONE:
  - Outputs hold the last applied values; done=1.
  - start: idx<=0, KEY_out<=all ones, SW_out<=0, go to LOAD.
  - abort: go to IDLE.
- Timing:
  - Start sampled on the edge ending cycle s.
  - Entry 0 values are visible from cycle s+delay0+4.
  - Each later entry becomes visible delay+3 cycles after the previous entry's change.
  - delay=0 gives a spacing of 3 cycles.
- Arithmetic: the delay counter is DELAY_W bits, decrement only, no wrap. Maximum hold is 2^DELAY_W+2 cycles per entry.
- start while busy: ignored.
- abort in LOAD/WAIT/APPLY/DONE: next state is IDLE, busy=0, done=0, passthrough resumes the following cycle.
- start and abort in the same cycle: abort wins.
- step_idx always equals idx.

Test Plan:
1. Reset held 2 cycles -> KEY_out=4'b1111, SW_out=0, busy=0, done=0. Then KEY_in=4'b1101, SW_in=10'h005 -> KEY_out=1101, SW_out=005 exactly 1 cycle later.
2. Four-entry script {D=4,key=1101,sw=0}, {D=4,key=1111,sw=0}, {D=7,key=1111,sw=002}, {D=9,key=1111,sw=006,last}, start at cycle s:
   - KEY_out[1]=0 from s+8 and back to 1 at s+15.
   - SW_out=002 at s+25, SW_out=006 at s+37.
   - busy=1 from s+1 to s+36; done=1 from s+37.
   - Further KEY_in changes do not affect the outputs.
3. Three entries with D=0 -> output changes exactly 3 cycles apart; step_idx goes 0,1,2.
4. loop=1, 2-entry script -> step_idx wraps 1->0 repeatedly and done never asserts. abort in WAIT -> busy=0 next cycle and passthrough resumes one cycle after that.
5. DEPTH=16 with no last flag set -> all 16 entries apply and the block enters DONE after idx=15.
6. During a run, each of these must be checked:
   - wr_en to entry 2 -> readback (second run) shows the old data.
   - start pulse -> no restart.
   - start+abort together -> IDLE.
   - reset mid-WAIT -> KEY_out=all ones, SW_out=0, IDLE on the next cycle.

Source files
------------

// File: rtl/input_script_player.sv
// input_script_player: replays a stored script of timed KEY/SW events, passes physical inputs through when idle.
// Ports: CLOCK_50/reset (sync, active-high); start/abort/loop control; KEY_in/SW_in physical inputs;
//        wr_* script write port (ignored while busy); KEY_out/SW_out registered outputs to the game core;
//        busy (LOAD/WAIT/APPLY), done (DONE), step_idx (current script entry).
module input_script_player #(
   parameter int N_KEYS  = 4,
   parameter int N_SW    = 10,
   parameter int DEPTH   = 16,
   parameter int DELAY_W = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               loop,
   input  logic [N_KEYS-1:0]  KEY_in,
   input  logic [N_SW-1:0]    SW_in,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DELAY_W-1:0] wr_delay,
   input  logic [N_KEYS-1:0]  wr_key,
   input  logic [N_SW-1:0]    wr_sw,
   input  logic               wr_last,
   output logic [N_KEYS-1:0]  KEY_out,
   output logic [N_SW-1:0]    SW_out,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      step_idx
);
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, APPLY, DONE} state_t;
   state_t state, state_n;
   logic [AW-1:0]      idx, idx_n;
   logic [DELAY_W-1:0] cnt, cnt_n;
   logic [N_KEYS-1:0]  key_n;
   logic [N_SW-1:0]    sw_n;
   logic [DELAY_W-1:0] mem_delay [DEPTH];
   logic [N_KEYS-1:0]  mem_key [DEPTH];
   logic [N_SW-1:0]    mem_sw [DEPTH];
   logic               mem_last [DEPTH];
   logic               at_end;
   assign busy     = state == LOAD || state == WAIT || state == APPLY;
   assign done     = state == DONE;
   assign step_idx = idx;
   assign at_end   = mem_last[idx] || idx == AW'(DEPTH - 1);
   // script memory survives reset so a loaded demo can be replayed after a board reset
   always_ff @(posedge CLOCK_50) begin
      if (wr_en && !busy) begin
         mem_delay[wr_addr] <= wr_delay;
         mem_key[wr_addr]   <= wr_key;
         mem_sw[wr_addr]    <= wr_sw;
         mem_last[wr_addr]  <= wr_last;
      end
   end
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         KEY_out <= '1;
         SW_out  <= '0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         cnt     <= cnt_n;
         KEY_out <= key_n;
         SW_out  <= sw_n;
      end
   end
   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      key_n   = KEY_out;
      sw_n    = SW_out;
      case (state)
         IDLE: begin
            key_n = KEY_in;
            sw_n  = SW_in;
            if (start && !abort) begin
               idx_n   = '0;
               key_n   = '1;
               sw_n    = '0;
               state_n = LOAD;
            end
         end
         LOAD: begin
            cnt_n   = mem_delay[idx];
            state_n = WAIT;
         end
         WAIT: begin
            if (cnt == '0) state_n = APPLY;
            else cnt_n = cnt - DELAY_W'(1);
         end
         APPLY: begin
            key_n   = mem_key[idx];
            sw_n    = mem_sw[idx];
            idx_n   = at_end ? (loop ? '0 : idx) : idx + AW'(1);
            state_n = (at_end && !loop) ? DONE : LOAD;
         end
         DONE: begin
            if (start) begin
               idx_n   = '0;
               key_n   = '1;
               sw_n    = '0;
               state_n = LOAD;
            end
         end
         default: state_n = IDLE;
      endcase
      // abort freezes everything and drops to IDLE; passthrough starts on the next cycle
      if (abort && state != IDLE) begin
         state_n = IDLE;
         idx_n   = idx;
         cnt_n   = cnt;
         key_n   = KEY_out;
         sw_n    = SW_out;
      end
   end
endmodule

// File: tb/tb_input_script_player.sv
// tb_input_script_player: directed bench for input_script_player (default parameters).
module tb_input_script_player;
   logic        CLOCK_50, reset, start, abort, loop;
   logic [3:0]  KEY_in, wr_addr, wr_key, KEY_out, step_idx;
   logic [9:0]  SW_in, wr_sw, SW_out;
   logic        wr_en, wr_last, busy, done;
   logic [15:0] wr_delay;
   int checks = 0;
   int errors = 0;

   input_script_player dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .abort(abort), .loop(loop),
      .KEY_in(KEY_in), .SW_in(SW_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_delay(wr_delay),
      .wr_key(wr_key), .wr_sw(wr_sw), .wr_last(wr_last), .KEY_out(KEY_out), .SW_out(SW_out),
      .busy(busy), .done(done), .step_idx(step_idx)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [3:0] k, input logic [9:0] s, input logic l);
      wr_addr = a; wr_delay = d; wr_key = k; wr_sw = s; wr_last = l; wr_en = 1'b1;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(2);
      checks++;
      if ({KEY_out, SW_out, busy, done, step_idx} !== {4'hF, 10'h000, 1'b0, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL reset got %b %h %b %b %0d", KEY_out, SW_out, busy, done, step_idx);
      end
      reset = 1'b0; KEY_in = 4'b1101; SW_in = 10'h005;
      checks++;
      if ({KEY_out, SW_out} !== {4'hF, 10'h000}) begin
         errors++;
         $display("FAIL passthrough_early got %b %h want 1111 000", KEY_out, SW_out);
      end
      tick(1);
      checks++;
      if ({KEY_out, SW_out} !== {4'b1101, 10'h005}) begin
         errors++;
         $display("FAIL passthrough got %b %h want 1101 005", KEY_out, SW_out);
      end
   endtask

   task automatic test_script;
      logic [3:0] ek, ei;
      logic [9:0] es;
      logic       eb, ed;
      wr(0, 4, 4'b1101, 10'h000, 0);
      wr(1, 4, 4'b1111, 10'h000, 0);
      wr(2, 7, 4'b1111, 10'h002, 0);
      wr(3, 9, 4'b1111, 10'h006, 1);
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick(1);
         start = 1'b0;
         ek = (c >= 8 && c < 15) ? 4'b1101 : 4'b1111;
         es = c >= 37 ? 10'h006 : c >= 25 ? 10'h002 : 10'h000;
         eb = c <= 36;
         ed = c >= 37;
         ei = c >= 25 ? 4'd3 : c >= 15 ? 4'd2 : c >= 8 ? 4'd1 : 4'd0;
         checks++;
         if ({KEY_out, SW_out, busy, done, step_idx} !== {ek, es, eb, ed, ei}) begin
            errors++;
            $display("FAIL script c=%0d got %b %h %b %b %0d want %b %h %b %b %0d", c, KEY_out, SW_out, busy, done, step_idx, ek, es, eb, ed, ei);
         end
         if (c == 10) begin
            KEY_in = 4'b0000; SW_in = 10'h3FF;
         end
      end
   endtask

   task automatic test_zero_delay;
      logic [3:0] ek, ei;
      logic [9:0] es;
      logic       ed;
      wr(0, 0, 4'b1110, 10'h001, 0);
      wr(1, 0, 4'b1101, 10'h002, 0);
      wr(2, 0, 4'b1011, 10'h003, 1);
      loop = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick(1);
         start = 1'b0;
         ek = c >= 10 ? 4'b1011 : c >= 7 ? 4'b1101 : c >= 4 ? 4'b1110 : 4'b1111;
         es = c >= 10 ? 10'h003 : c >= 7 ? 10'h002 : c >= 4 ? 10'h001 : 10'h000;
         ei = c >= 7 ? 4'd2 : c >= 4 ? 4'd1 : 4'd0;
         ed = c >= 10;
         checks++;
         if ({KEY_out, SW_out, done, step_idx} !== {ek, es, ed, ei}) begin
            errors++;
            $display("FAIL zero_delay c=%0d got %b %h %b %0d want %b %h %b %0d", c, KEY_out, SW_out, done, step_idx, ek, es, ed, ei);
         end
      end
   endtask

   task automatic test_loop_abort;
      logic [3:0] ek, ei;
      logic [9:0] es;
      logic       ph;
      wr(0, 1, 4'b1110, 10'h001, 0);
      wr(1, 1, 4'b0111, 10'h002, 1);
      loop = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick(1);
         start = 1'b0;
         ph = c >= 5 && ((c - 5) % 8) < 4;
         ek = c < 5 ? 4'b1111 : ph ? 4'b1110 : 4'b0111;
         es = c < 5 ? 10'h000 : ph ? 10'h001 : 10'h002;
         ei = ph ? 4'd1 : 4'd0;
         checks++;
         if ({KEY_out, SW_out, busy, done, step_idx} !== {ek, es, 1'b1, 1'b0, ei}) begin
            errors++;
            $display("FAIL loop c=%0d got %b %h %b %b %0d want %b %h 1 0 %0d", c, KEY_out, SW_out, busy, done, step_idx, ek, es, ei);
         end
      end
      abort = 1'b1; loop = 1'b0; KEY_in = 4'b1010; SW_in = 10'h155;
      tick(1);
      abort = 1'b0;
      checks++;
      if ({KEY_out, SW_out, busy, done, step_idx} !== {4'b1110, 10'h001, 1'b0, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL abort got %b %h %b %b %0d want 1110 001 0 0 1", KEY_out, SW_out, busy, done, step_idx);
      end
      tick(1);
      checks++;
      if ({KEY_out, SW_out, busy, done} !== {4'b1010, 10'h155, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort_passthrough got %b %h %b %b want 1010 155 0 0", KEY_out, SW_out, busy, done);
      end
   endtask

   task automatic test_full_depth;
      logic [3:0] ek, ei;
      logic [9:0] es;
      logic       eb, ed;
      int         e;
      for (int i = 0; i < 16; i++) wr(4'(i), 0, ~4'(i), 10'(i), 0);
      start = 1'b1;
      for (int c = 1; c <= 52; c++) begin
         tick(1);
         start = 1'b0;
         e  = c < 4 ? -1 : ((c - 4) / 3 > 15 ? 15 : (c - 4) / 3);
         ek = e < 0 ? 4'hF : ~4'(e);
         es = e < 0 ? 10'h000 : 10'(e);
         ei = c < 4 ? 4'd0 : (e + 1 > 15 ? 4'd15 : 4'(e + 1));
         eb = c <= 48;
         ed = c >= 49;
         checks++;
         if ({KEY_out, SW_out, busy, done, step_idx} !== {ek, es, eb, ed, ei}) begin
            errors++;
            $display("FAIL depth c=%0d got %b %h %b %b %0d want %b %h %b %b %0d", c, KEY_out, SW_out, busy, done, step_idx, ek, es, eb, ed, ei);
         end
      end
   endtask

   task automatic run_three(input logic disturb);
      logic [3:0] ek, ei;
      logic [9:0] es;
      logic       eb, ed;
      start = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick(1);
         start = disturb && c == 5;
         wr_addr = 4'd2; wr_delay = 16'd0; wr_key = 4'b0000; wr_sw = 10'h3FF; wr_last = 1'b0;
         wr_en = disturb && c == 3;
         ek = c >= 25 ? 4'b1011 : c >= 17 ? 4'b1101 : c >= 9 ? 4'b1110 : 4'b1111;
         es = c >= 25 ? 10'h033 : c >= 17 ? 10'h022 : c >= 9 ? 10'h011 : 10'h000;
         ei = c >= 17 ? 4'd2 : c >= 9 ? 4'd1 : 4'd0;
         eb = c <= 24;
         ed = c >= 25;
         checks++;
         if ({KEY_out, SW_out, busy, done, step_idx} !== {ek, es, eb, ed, ei}) begin
            errors++;
            $display("FAIL run%0d c=%0d got %b %h %b %b %0d want %b %h %b %b %0d", disturb, c, KEY_out, SW_out, busy, done, step_idx, ek, es, eb, ed, ei);
         end
      end
      start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic test_during_run;
      wr(0, 5, 4'b1110, 10'h011, 0);
      wr(1, 5, 4'b1101, 10'h022, 0);
      wr(2, 5, 4'b1011, 10'h033, 1);
      run_three(1'b1);
      run_three(1'b0);
      start = 1'b1; abort = 1'b1; KEY_in = 4'b0110; SW_in = 10'h0AA;
      tick(1);
      start = 1'b0; abort = 1'b0;
      checks++;
      if ({KEY_out, SW_out, busy, done} !== {4'b1011, 10'h033, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL start_abort got %b %h %b %b want 1011 033 0 0", KEY_out, SW_out, busy, done);
      end
      tick(1);
      checks++;
      if ({KEY_out, SW_out, busy, done} !== {4'b0110, 10'h0AA, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL start_abort_idle got %b %h %b %b want 0110 0aa 0 0", KEY_out, SW_out, busy, done);
      end
      start = 1'b1;
      tick(12);
      start = 1'b0;
      checks++;
      if ({KEY_out, SW_out, busy, step_idx} !== {4'b1110, 10'h011, 1'b1, 4'd1}) begin
         errors++;
         $display("FAIL pre_reset got %b %h %b %0d want 1110 011 1 1", KEY_out, SW_out, busy, step_idx);
      end
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checks++;
      if ({KEY_out, SW_out, busy, done, step_idx} !== {4'hF, 10'h000, 1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL mid_reset got %b %h %b %b %0d want 1111 000 0 0 0", KEY_out, SW_out, busy, done, step_idx);
      end
      tick(1);
      checks++;
      if ({KEY_out, SW_out, busy} !== {4'b0110, 10'h0AA, 1'b0}) begin
         errors++;
         $display("FAIL post_reset got %b %h %b want 0110 0aa 0", KEY_out, SW_out, busy);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
      KEY_in = 4'hF; SW_in = 10'h000;
      wr_en = 1'b0; wr_addr = '0; wr_delay = '0; wr_key = '0; wr_sw = '0; wr_last = 1'b0;
      test_reset;
      test_script;
      test_zero_delay;
      test_loop_abort;
      test_full_depth;
      test_during_run;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
